// File: rtl/queue_param.sv
// queue_param: single-clock FIFO with configurable width/depth, first-word-fall-through
// read data, occupancy count, almost-full/almost-empty levels, sticky error flags and flush.
module queue_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic                     rd,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    // Status and head data decoded from registered pointers only.
    always_comb begin
        count        = wr_ptr - rd_ptr;
        empty        = (rd_ptr == wr_ptr);
        full         = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
        almost_full  = (count >= PW'(AF_LEVEL));
        almost_empty = (count <= PW'(AE_LEVEL));
        dout         = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    // A write into a full queue is allowed when the head is popped on the same edge.
    always_comb begin
        rd_ok = rd & ~empty & ~flush;
        wr_ok = wr & (~full | rd) & ~flush;
    end

    // Pointer and sticky error flag update; flush clears everything and ignores requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
            if (wr & ~wr_ok) overflow  <= 1'b1;
            if (rd & ~rd_ok) underflow <= 1'b1;
        end
    end

    // Storage array is not reset; only pointers define valid contents.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: tb/tb_queue_param.sv
// tb_queue_param: directed scoreboard bench for queue_param at 8x8 and 16x12.
module tb_queue_param;

    logic clk;
    logic reset;

    // 8-deep, 8-bit instance
    logic       wr8, rd8, flush8;
    logic [7:0] din8, dout8;
    logic       empty8, full8, ae8, af8, ovf8, udf8;
    logic [3:0] count8;

    // 16-deep, 12-bit instance
    logic        wr16, rd16, flush16;
    logic [11:0] din16, dout16;
    logic        empty16, full16, ae16, af16, ovf16, udf16;
    logic [4:0]  count16;

    int tests;
    int fails;

    logic [7:0]  sb8[$];
    logic [11:0] sb16[$];
    logic        movf8, mudf8, movf16;

    queue_param u8 (
        .clk(clk), .reset(reset), .wr(wr8), .rd(rd8), .flush(flush8), .din(din8),
        .dout(dout8), .empty(empty8), .full(full8), .almost_empty(ae8),
        .almost_full(af8), .count(count8), .overflow(ovf8), .underflow(udf8)
    );

    queue_param #(.WIDTH(12), .DEPTH(16)) u16 (
        .clk(clk), .reset(reset), .wr(wr16), .rd(rd16), .flush(flush16), .din(din16),
        .dout(dout16), .empty(empty16), .full(full16), .almost_empty(ae16),
        .almost_full(af16), .count(count16), .overflow(ovf16), .underflow(udf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full status check of the 8-deep instance against the scoreboard.
    task automatic status8(input string tag);
        int n;
        n = sb8.size();
        check({tag, ".count"}, 32'(count8), 32'(n));
        check({tag, ".empty"}, 32'(empty8), 32'(n == 0));
        check({tag, ".full"},  32'(full8),  32'(n == 8));
        check({tag, ".af"},    32'(af8),    32'(n >= 7));
        check({tag, ".ae"},    32'(ae8),    32'(n <= 1));
        check({tag, ".ovf"},   32'(ovf8),   32'(movf8));
        check({tag, ".udf"},   32'(udf8),   32'(mudf8));
        check({tag, ".dout"},  32'(dout8),  (n == 0) ? 32'h0 : 32'(sb8[0]));
    endtask

    // One clock of stimulus on the 8-deep instance with scoreboard update.
    task automatic op8(input logic w, input logic r, input logic f, input logic [7:0] d);
        logic rok, wok;
        wr8 = w; rd8 = r; flush8 = f; din8 = d;
        if (f) begin
            sb8.delete();
            movf8 = 1'b0;
            mudf8 = 1'b0;
        end else begin
            rok = r && (sb8.size() > 0);
            wok = w && ((sb8.size() < 8) || r);
            if (rok) check("rd_data8", 32'(dout8), 32'(sb8.pop_front()));
            if (w && !wok) movf8 = 1'b1;
            if (r && !rok) mudf8 = 1'b1;
            if (wok) sb8.push_back(d);
        end
        @(posedge clk);
        #1;
        wr8 = 1'b0; rd8 = 1'b0; flush8 = 1'b0;
        status8("op8");
    endtask

    // One clock of stimulus on the 16-deep instance.
    task automatic op16(input logic w, input logic r, input logic [11:0] d);
        logic rok, wok;
        wr16 = w; rd16 = r; din16 = d;
        rok = r && (sb16.size() > 0);
        wok = w && ((sb16.size() < 16) || r);
        if (rok) check("rd_data16", 32'(dout16), 32'(sb16.pop_front()));
        if (w && !wok) movf16 = 1'b1;
        if (wok) sb16.push_back(d);
        @(posedge clk);
        #1;
        wr16 = 1'b0; rd16 = 1'b0;
        check("count16", 32'(count16), 32'(sb16.size()));
        check("full16",  32'(full16),  32'(sb16.size() == 16));
        check("empty16", 32'(empty16), 32'(sb16.size() == 0));
        check("ovf16",   32'(ovf16),   32'(movf16));
    endtask

    initial begin
        tests = 0; fails = 0;
        movf8 = 1'b0; mudf8 = 1'b0; movf16 = 1'b0;
        wr8 = 0; rd8 = 0; flush8 = 0; din8 = '0;
        wr16 = 0; rd16 = 0; flush16 = 0; din16 = '0;
        reset = 1'b0;

        // Reset values
        #12;
        status8("reset");
        check("reset.count16", 32'(count16), 32'h0);
        check("reset.dout16",  32'(dout16),  32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Fill 0x01..0x08, overflow on ninth write, drain in order
        for (int i = 1; i <= 8; i++) op8(1, 0, 0, 8'(i));
        op8(1, 0, 0, 8'hFF);
        for (int i = 0; i < 8; i++) op8(0, 1, 0, 8'h00);

        // Full queue with simultaneous wr/rd: head advances, count holds, no overflow
        op8(0, 0, 1, 8'h00);
        for (int i = 1; i <= 8; i++) op8(1, 0, 0, 8'(i));
        op8(1, 1, 0, 8'hAA);
        for (int i = 0; i < 8; i++) op8(0, 1, 0, 8'h00);

        // Empty read sets underflow; wr+rd on empty accepts only the write
        op8(0, 1, 0, 8'h00);
        op8(1, 1, 0, 8'h55);
        op8(0, 1, 0, 8'h00);

        // Wrap-around: alternate single write and single read
        for (int i = 0; i < 20; i++) op8((i % 2) == 0, (i % 2) == 1, 0, 8'(8'h30 + i));

        // Flush with count=5 and overflow set, write in the same cycle is discarded
        op8(0, 0, 1, 8'h00);
        for (int i = 1; i <= 9; i++) op8(1, 0, 0, 8'(8'h40 + i));
        for (int i = 0; i < 3; i++) op8(0, 1, 0, 8'h00);
        op8(1, 0, 1, 8'hEE);

        // Asynchronous reset mid-fill takes effect between clock edges
        for (int i = 1; i <= 3; i++) op8(1, 0, 0, 8'(8'h60 + i));
        #2;
        reset = 1'b0;
        #1;
        sb8.delete(); movf8 = 1'b0; mudf8 = 1'b0;
        status8("midreset");
        @(posedge clk); #1;
        reset = 1'b1;

        // 16x12 instance: fill, overflow, drain
        for (int i = 1; i <= 16; i++) op16(1, 0, 12'(12'h100 * i + i));
        op16(1, 0, 12'hFFF);
        op16(1, 1, 12'hABC);
        for (int i = 0; i < 16; i++) op16(0, 1, 12'h000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
